// File: rtl/altair_pkg.sv
// Shared types and sizes for the Altair main-RAM arbiter.
package altair_pkg;

    localparam int ALTAIR_ADDR_BITS = 16;
    localparam int ALTAIR_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_SPI = 1'b1
    } grant_e;

endpackage

// File: rtl/spi_req_capture.sv
// One-entry buffer for single-cycle SPI wr/rd strobes, with overrun flag and
// SPI address window decode.
module spi_req_capture
    import altair_pkg::*;
#(
    parameter int          ADDR_BITS = ALTAIR_ADDR_BITS,
    parameter int          DATA_BITS = ALTAIR_DATA_BITS,
    parameter logic [31:0] SPI_BASE  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_wr,
    input  logic                 spi_rd,
    input  logic [31:0]          spi_addr,
    input  logic [DATA_BITS-1:0] spi_wdata,
    input  logic                 pop,
    output logic                 pending,
    output logic                 op_we,
    output logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] data,
    output logic                 in_window,
    output logic                 overrun
);

    logic                 pending_q, pending_d;
    logic                 op_we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 in_window_q;
    logic                 overrun_q;

    logic strobe;
    logic accept;
    logic drop;
    logic win_hit;

    always_comb begin
        strobe    = spi_wr | spi_rd;
        accept    = strobe & ~pending_q;
        // A simultaneous wr+rd always loses the read, even into an empty buffer.
        drop      = (strobe & pending_q) | (spi_wr & spi_rd);
        win_hit   = (spi_addr[31:ADDR_BITS] == SPI_BASE[31:ADDR_BITS]);
        pending_d = pending_q;
        if (pop) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= 1'b0;
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            in_window_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept) begin
                op_we_q     <= spi_wr;
                addr_q      <= spi_addr[ADDR_BITS-1:0];
                data_q      <= spi_wdata;
                in_window_q <= win_hit;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign pending   = pending_q;
    assign op_we     = op_we_q;
    assign addr      = addr_q;
    assign data      = data_q;
    assign in_window = in_window_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/altair_ram_arbiter.sv
// Round-robin arbiter sharing the single-port Altair main RAM between the 8080
// core and the ESP32 SPI port. One access per IDLE -> ACC -> DONE slot.
module altair_ram_arbiter
    import altair_pkg::*;
#(
    parameter int                   ADDR_BITS = ALTAIR_ADDR_BITS,
    parameter int                   DATA_BITS = ALTAIR_DATA_BITS,
    parameter logic [31:0]          SPI_BASE  = 32'h0000_0000,
    parameter logic [DATA_BITS-1:0] OOW_RDATA = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    output logic [DATA_BITS-1:0] cpu_rdata,
    output logic                 cpu_ack,
    input  logic                 spi_wr,
    input  logic                 spi_rd,
    input  logic [31:0]          spi_addr,
    input  logic [DATA_BITS-1:0] spi_wdata,
    output logic [DATA_BITS-1:0] spi_rdata,
    output logic                 spi_rvalid,
    output logic                 spi_overrun,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_we,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    arb_state_e           state_q, state_d;
    grant_e               grant_q, grant_d;
    grant_e               last_grant_q, last_grant_d;
    logic                 op_we_q, op_we_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic                 ram_we_q, ram_we_d;
    logic [DATA_BITS-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_BITS-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_BITS-1:0] spi_rdata_q, spi_rdata_d;

    logic                 spi_pending;
    logic                 spi_op_we;
    logic [ADDR_BITS-1:0] spi_op_addr;
    logic [DATA_BITS-1:0] spi_op_data;
    logic                 spi_in_window;
    logic                 spi_pop;
    logic                 cpu_done;
    logic                 spi_done;

    spi_req_capture #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .SPI_BASE  (SPI_BASE)
    ) u_spi_capture (
        .clk       (clk),
        .reset     (reset),
        .spi_wr    (spi_wr),
        .spi_rd    (spi_rd),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .pop       (spi_pop),
        .pending   (spi_pending),
        .op_we     (spi_op_we),
        .addr      (spi_op_addr),
        .data      (spi_op_data),
        .in_window (spi_in_window),
        .overrun   (spi_overrun)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_we_d      = op_we_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        spi_rdata_d  = spi_rdata_q;
        spi_pop      = 1'b0;
        cpu_done     = 1'b0;
        spi_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || spi_pending) begin
                    if (cpu_req && spi_pending) begin
                        grant_d = (last_grant_q == GNT_CPU) ? GNT_SPI : GNT_CPU;
                    end else if (cpu_req) begin
                        grant_d = GNT_CPU;
                    end else begin
                        grant_d = GNT_SPI;
                    end
                    last_grant_d = grant_d;
                    state_d      = ACC;
                    if (grant_d == GNT_CPU) begin
                        op_we_d     = cpu_we;
                        ram_addr_d  = cpu_addr;
                        ram_we_d    = cpu_we;
                        ram_wdata_d = cpu_wdata;
                    end else begin
                        op_we_d = spi_op_we;
                        // Out-of-window ops burn the slot but never touch the RAM.
                        if (spi_in_window) begin
                            ram_addr_d  = spi_op_addr;
                            ram_we_d    = spi_op_we;
                            ram_wdata_d = spi_op_data;
                        end
                    end
                end
            end
            ACC: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (grant_q == GNT_CPU) begin
                    cpu_done = 1'b1;
                    if (!op_we_q) begin
                        cpu_rdata_d = ram_rdata;
                    end
                end else begin
                    spi_pop = 1'b1;
                    if (!op_we_q) begin
                        spi_done    = 1'b1;
                        spi_rdata_d = spi_in_window ? ram_rdata : OOW_RDATA;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_CPU;
            last_grant_q <= GNT_SPI;
            op_we_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            spi_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_we_q      <= op_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            spi_rdata_q  <= spi_rdata_d;
        end
    end

    // Strobes are masked by reset so an access interrupted in ACC/DONE has no effect.
    assign ram_we     = ram_we_q & ~reset;
    assign cpu_ack    = cpu_done & ~reset;
    assign spi_rvalid = spi_done & ~reset;
    assign cpu_rdata  = cpu_rdata_d;
    assign spi_rdata  = spi_rdata_d;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign busy       = (state_q != IDLE) | spi_pending;

endmodule

// File: tb/tb_altair_ram_arbiter.sv
// Self-checking bench for altair_ram_arbiter: directed tables, contention and
// overrun sequences, reset abort, and a randomized two-port run against a memory model.
module tb_altair_ram_arbiter;

    logic        clk, reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        spi_wr, spi_rd, spi_rvalid, spi_overrun, busy;
    logic [31:0] spi_addr;
    logic [7:0]  spi_wdata, spi_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    bit [7:0] ram     [65536];
    bit [7:0] ref_mem [65536];
    int       checks = 0;
    int       errors = 0;
    bit       log_en = 0;
    int       grant_log[$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rdata;
    } cpu_vec_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [7:0]  wd;
        int          exp_rv;
        logic [7:0]  exp_rdata;
        int          exp_we;
    } spi_vec_t;

    altair_ram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .spi_wr      (spi_wr),
        .spi_rd      (spi_rd),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata),
        .spi_rvalid  (spi_rvalid),
        .spi_overrun (spi_overrun),
        .busy        (busy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM, one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    always @(negedge clk) begin
        if (log_en) begin
            if (cpu_ack)    grant_log.push_back(0);
            if (spi_rvalid) grant_log.push_back(1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut(input string tag);
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0; spi_wr = 1'b0; spi_rd = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk({tag, ".cpu_ack"},     cpu_ack,     0);
        chk({tag, ".cpu_rdata"},   cpu_rdata,   0);
        chk({tag, ".spi_rdata"},   spi_rdata,   0);
        chk({tag, ".spi_rvalid"},  spi_rvalid,  0);
        chk({tag, ".spi_overrun"}, spi_overrun, 0);
        chk({tag, ".busy"},        busy,        0);
        chk({tag, ".ram_addr"},    ram_addr,    0);
        chk({tag, ".ram_we"},      ram_we,      0);
        chk({tag, ".ram_wdata"},   ram_wdata,   0);
    endtask

    // Request raised just after a posedge; c counts negedges from that cycle.
    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd,
                          output logic we_at1, output logic [15:0] addr_at1);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = -1; rd = 8'h00; we_at1 = 1'b0; addr_at1 = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                we_at1   = ram_we;
                addr_at1 = ram_addr;
            end
            if (cpu_ack) begin
                lat = c;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (lat < 0) chk("cpu_op.timeout", 1, 0);
        else if (we) ref_mem[a] = wd;
    endtask

    task automatic spi_op(input logic wr, input logic rd, input logic [31:0] a, input logic [7:0] wd,
                          input int wait_cyc, output int rv_cnt, output logic [7:0] rv_data,
                          output int rv_lat, output int we_cnt);
        @(posedge clk); #1;
        spi_wr = wr; spi_rd = rd; spi_addr = a; spi_wdata = wd;
        @(posedge clk); #1;
        spi_wr = 1'b0; spi_rd = 1'b0;
        rv_cnt = 0; we_cnt = 0; rv_lat = -1; rv_data = 8'h00;
        for (int c = 1; c <= wait_cyc; c++) begin
            @(negedge clk);
            if (spi_rvalid) begin
                rv_cnt++;
                rv_data = spi_rdata;
                if (rv_lat < 0) rv_lat = c;
            end
            if (ram_we) we_cnt++;
        end
        if (wr && a[31:16] == 16'h0000) ref_mem[a[15:0]] = wd;
    endtask

    initial begin
        cpu_vec_t    cv[5];
        spi_vec_t    sv[8];
        int          lat, rv_cnt, rv_lat, we_cnt;
        logic [7:0]  rd, rv_data;
        logic        we1, ack_seen;
        logic [15:0] a1;

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = '0; spi_wdata = '0;

        reset_dut("rst0");

        // CPU directed table; exp_rdata is cpu_rdata after the op (writes leave it).
        cv[0] = '{1'b1, 16'h0100, 8'hC3, 8'h00};
        cv[1] = '{1'b0, 16'h0100, 8'h00, 8'hC3};
        cv[2] = '{1'b1, 16'hFFFF, 8'h5A, 8'hC3};
        cv[3] = '{1'b0, 16'hFFFF, 8'h00, 8'h5A};
        cv[4] = '{1'b0, 16'h0100, 8'h00, 8'hC3};
        for (int i = 0; i < 5; i++) begin
            cpu_op(cv[i].we, cv[i].addr, cv[i].wd, lat, rd, we1, a1);
            chk($sformatf("cpu[%0d].ack_latency", i), lat, 2);
            chk($sformatf("cpu[%0d].ram_we_n1", i), we1, cv[i].we);
            chk($sformatf("cpu[%0d].ram_addr_n1", i), a1, cv[i].addr);
            chk($sformatf("cpu[%0d].rdata", i), rd, cv[i].exp_rdata);
        end
        chk("cpu.ram_0100", ram[16'h0100], 8'hC3);

        // SPI directed table incl. out-of-window ops.
        sv[0] = '{1'b1, 1'b0, 32'h0000_0010, 8'h3E, 0, 8'h00, 1};
        sv[1] = '{1'b0, 1'b1, 32'h0000_0010, 8'h00, 1, 8'h3E, 0};
        sv[2] = '{1'b0, 1'b1, 32'h0001_0000, 8'h00, 1, 8'hFF, 0};
        sv[3] = '{1'b1, 1'b0, 32'h0001_0010, 8'h77, 0, 8'hFF, 0};
        sv[4] = '{1'b0, 1'b1, 32'h0000_0010, 8'h00, 1, 8'h3E, 0};
        sv[5] = '{1'b1, 1'b0, 32'hFFFF_0011, 8'h55, 0, 8'h3E, 0};
        sv[6] = '{1'b1, 1'b0, 32'h0000_FFFE, 8'hA5, 0, 8'h3E, 1};
        sv[7] = '{1'b0, 1'b1, 32'h0000_FFFE, 8'h00, 1, 8'hA5, 0};
        for (int i = 0; i < 8; i++) begin
            spi_op(sv[i].wr, sv[i].rd, sv[i].addr, sv[i].wd, 6, rv_cnt, rv_data, rv_lat, we_cnt);
            chk($sformatf("spi[%0d].rvalid_count", i), rv_cnt, sv[i].exp_rv);
            if (sv[i].exp_rv == 1) chk($sformatf("spi[%0d].rvalid_latency", i), rv_lat, 3);
            chk($sformatf("spi[%0d].spi_rdata", i), spi_rdata, sv[i].exp_rdata);
            chk($sformatf("spi[%0d].ram_we_count", i), we_cnt, sv[i].exp_we);
            chk($sformatf("spi[%0d].busy_after", i), busy, 0);
        end
        chk("spi.ram_0010", ram[16'h0010], 8'h3E);
        chk("spi.ram_0011", ram[16'h0011], 8'h00);
        chk("spi.ram_FFFE", ram[16'hFFFE], 8'hA5);

        // Contention: CPU wins the first tie after reset, then strict alternation.
        reset_dut("rst1");
        grant_log.delete();
        log_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    bit got;
                    @(posedge clk); #1;
                    spi_rd = 1'b1; spi_addr = 32'h0000_0010 + 32'(k);
                    @(posedge clk); #1;
                    spi_rd = 1'b0;
                    got = 1'b0;
                    for (int c = 0; c < 30 && !got; c++) begin
                        @(negedge clk);
                        if (spi_rvalid) begin
                            got = 1'b1;
                            chk($sformatf("cont.spi_rdata[%0d]", k), spi_rdata, ref_mem[16'h0010 + 16'(k)]);
                        end
                    end
                    if (!got) chk("cont.spi_timeout", 1, 0);
                end
            end
            begin
                @(posedge clk);
                @(posedge clk); #1;
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
                for (int k = 0; k < 4; k++) begin
                    bit got;
                    got = 1'b0;
                    for (int c = 0; c < 30 && !got; c++) begin
                        @(negedge clk);
                        if (cpu_ack) begin
                            got = 1'b1;
                            chk($sformatf("cont.cpu_rdata[%0d]", k), cpu_rdata, ref_mem[cpu_addr]);
                            cpu_addr = cpu_addr + 16'h0001;
                        end
                    end
                    if (!got) chk("cont.cpu_timeout", 1, 0);
                end
                cpu_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        log_en = 1'b0;
        chk("cont.grant_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++)
            chk($sformatf("cont.grant[%0d]", i), grant_log[i], i % 2);
        chk("cont.overrun", spi_overrun, 0);

        // Randomized concurrent traffic; CPU uses 0x80xx, SPI uses 0x00xx plus out-of-window.
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic        w;
                    logic [15:0] a;
                    logic [7:0]  d;
                    logic [7:0]  exp;
                    w = 1'($urandom_range(0, 1));
                    a = {8'h80, 8'($urandom)};
                    d = 8'($urandom);
                    exp = ref_mem[a];
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    cpu_op(w, a, d, lat, rd, we1, a1);
                    chk($sformatf("rnd.cpu[%0d].fair_latency", n), (lat >= 0 && lat <= 5), 1);
                    if (!w) chk($sformatf("rnd.cpu[%0d].rdata", n), rd, exp);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    logic        w;
                    logic [31:0] a;
                    logic [7:0]  exp;
                    int          rc, rl, wc;
                    logic [7:0]  rdv;
                    w = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) a = {16'($urandom_range(1, 65535)), 8'h00, 8'($urandom)};
                    else                           a = {24'h0, 8'($urandom)};
                    exp = (a[31:16] == 16'h0000) ? ref_mem[a[15:0]] : 8'hFF;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    spi_op(w, ~w, a, 8'($urandom), 12, rc, rdv, rl, wc);
                    chk($sformatf("rnd.spi[%0d].rvalid_count", n), rc, w ? 0 : 1);
                    if (!w) chk($sformatf("rnd.spi[%0d].rdata", n), rdv, exp);
                end
            end
        join
        chk("rnd.overrun", spi_overrun, 0);

        // wr+rd in the same cycle: write kept, read dropped, overrun raised.
        reset_dut("rst2");
        spi_op(1'b1, 1'b1, 32'h0000_0032, 8'hC3, 6, rv_cnt, rv_data, rv_lat, we_cnt);
        chk("conflict.rvalid_count", rv_cnt, 0);
        chk("conflict.ram_we_count", we_cnt, 1);
        chk("conflict.ram_0032", ram[16'h0032], 8'hC3);
        chk("conflict.overrun", spi_overrun, 1);
        reset_dut("rst3");

        // Two SPI writes on consecutive cycles while the CPU owns the RAM.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8200; cpu_wdata = 8'h44;
        @(posedge clk); #1;
        spi_wr = 1'b1; spi_addr = 32'h0000_0030; spi_wdata = 8'hA1;
        @(posedge clk); #1;
        spi_addr = 32'h0000_0031; spi_wdata = 8'hB2; cpu_req = 1'b0;
        @(posedge clk); #1;
        spi_wr = 1'b0;
        repeat (8) @(negedge clk);
        ref_mem[16'h0030] = 8'hA1;
        ref_mem[16'h8200] = 8'h44;
        chk("overrun.ram_0030", ram[16'h0030], 8'hA1);
        chk("overrun.ram_0031", ram[16'h0031], ref_mem[16'h0031]);
        chk("overrun.ram_8200", ram[16'h8200], 8'h44);
        chk("overrun.flag", spi_overrun, 1);
        repeat (20) @(negedge clk);
        chk("overrun.sticky", spi_overrun, 1);
        chk("overrun.busy", busy, 0);

        // Reset during ACC of a CPU write aborts it.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h99;
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        chk("abort.ram_we_in_reset", ram_we, 0);
        chk("abort.cpu_ack_in_reset", cpu_ack, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack || ram_we) ack_seen = 1'b1;
        end
        chk("abort.no_ack_or_we", ack_seen, 0);
        chk("abort.ram_0200", ram[16'h0200], 8'h00);
        chk("abort.ram_addr", ram_addr, 0);
        chk("abort.busy", busy, 0);
        chk("abort.overrun_cleared", spi_overrun, 0);
        chk("abort.spi_rdata", spi_rdata, 0);
        chk("abort.cpu_rdata", cpu_rdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
